// File: rtl/fft_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_sched
// Purpose  : Frame scheduler for the 8-point pipelined FFT chain
//            (stage_8 -> stage_4 -> stage_2 -> ping_pong_access). Accepts
//            butterfly input pairs on a valid/ready handshake, produces the
//            per-stage butterfly controls, sequences the ping-pong buffer
//            write/read ports and flags output frame boundaries.
// Ports    : clk, rst (async, active-high)
//            in_valid / in_ready          input pair handshake
//            s8_ctl, s4_ctl               stage_8 / stage_4 control
//            wr_en, wr_addr, wr_bank      ping-pong write port
//            rd_en, rd_addr, rd_bank      ping-pong read port
//            out_valid/first/last         output bin qualifiers
//            frame_cnt                    completed output frames (wraps)
//            err_abort                    sticky truncated-frame flag
// Options  : FFT_BITREV_RD_EN - read addresses in 3-bit bit-reversed order.
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_sched #(
    parameter int N_PAIRS  = 4,
    parameter int PIPE_LAT = 12,
    parameter int S4_DLY   = 4,
    parameter int RD_LAT   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] s8_ctl,
    output logic [1:0] s4_ctl,
    output logic       wr_en,
    output logic [1:0] wr_addr,
    output logic       wr_bank,
    output logic       rd_en,
    output logic [2:0] rd_addr,
    output logic       rd_bank,
    output logic       out_valid,
    output logic       out_first,
    output logic       out_last,
    output logic [7:0] frame_cnt,
    output logic       err_abort
);

    localparam logic [1:0] c_LAST_IDX = 2'(N_PAIRS - 1);
    localparam logic [2:0] c_GAP_END  = 3'(8 - N_PAIRS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, GAP = 2'd2} in_state_t;
    typedef enum logic       {RIDLE = 1'b0, READ = 1'b1} rd_state_t;

    // Token layout: [4] valid, [3:2] pair index, [1] first, [0] last
    in_state_t  in_state_q, in_state_d;
    logic [1:0] idx_q, idx_d;
    logic [2:0] gap_q, gap_d;
    logic       in_ready_q, in_ready_d;
    logic       err_q, err_d;
    logic [4:0] tok_in;
    logic [4:0] dl_q [PIPE_LAT];
    logic [4:0] dl_d [PIPE_LAT];
    logic [1:0] s4_q [S4_DLY];
    logic [1:0] s4_d [S4_DLY];
    logic       wr_bank_q, wr_bank_d;
    rd_state_t  rd_state_q, rd_state_d;
    logic [2:0] rd_cnt_q, rd_cnt_d;
    logic       rd_bank_q, rd_bank_d;
    logic [2:0] fl_q [RD_LAT];
    logic [2:0] fl_d [RD_LAT];
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       w_accept;
    logic [4:0] w_tok_out;
    logic       w_trig;

    assign w_accept  = in_valid && in_ready_q;
    assign w_tok_out = dl_q[PIPE_LAT-1];
    assign w_trig    = w_tok_out[4] && w_tok_out[0];

    // Input handshake FSM and token generation
    always_comb begin
        in_state_d = in_state_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        err_d      = err_q;
        tok_in     = '0;
        unique case (in_state_q)
            IDLE: begin
                if (w_accept) begin
                    tok_in     = {1'b1, 2'd0, 1'b1, (c_LAST_IDX == 2'd0)};
                    idx_d      = 2'd1;
                    in_state_d = FILL;
                end
            end
            FILL: begin
                if (in_valid) begin
                    tok_in = {1'b1, idx_q, 1'b0, (idx_q == c_LAST_IDX)};
                    if (idx_q == c_LAST_IDX) begin
                        idx_d      = 2'd0;
                        gap_d      = 3'd0;
                        in_state_d = GAP;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    // Source stalled mid-frame: drop the partial frame
                    idx_d      = 2'd0;
                    err_d      = 1'b1;
                    in_state_d = IDLE;
                end
            end
            GAP: begin
                // Hold off input so frames never outrun the 8-cycle read
                if (gap_q == c_GAP_END) begin
                    in_state_d = IDLE;
                end else begin
                    gap_d = gap_q + 3'd1;
                end
            end
            default: begin
                idx_d      = 2'd0;
                in_state_d = IDLE;
            end
        endcase
        in_ready_d = (in_state_d != GAP);
    end

    // Token delay line and stage_4 control delay
    always_comb begin
        dl_d[0] = tok_in;
        for (int i = 1; i < PIPE_LAT; i++) begin
            dl_d[i] = dl_q[i-1];
        end
        s4_d[0] = idx_q;
        for (int i = 1; i < S4_DLY; i++) begin
            s4_d[i] = s4_q[i-1];
        end
    end

    // Write bank flips after the last pair of a frame lands; read FSM
    // drains the bank just filled.
    always_comb begin
        wr_bank_d  = wr_bank_q ^ w_trig;
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_bank_d  = rd_bank_q;
        unique case (rd_state_q)
            RIDLE: begin
                if (w_trig) begin
                    rd_state_d = READ;
                    rd_cnt_d   = 3'd0;
                    rd_bank_d  = wr_bank_q;
                end
            end
            READ: begin
                if (rd_cnt_q == 3'd7) begin
                    rd_cnt_d = 3'd0;
                    if (w_trig) begin
                        // Back-to-back frame: continue without a bubble
                        rd_bank_d = wr_bank_q;
                    end else begin
                        rd_state_d = RIDLE;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + 3'd1;
                end
            end
            default: begin
                rd_state_d = RIDLE;
                rd_cnt_d   = 3'd0;
            end
        endcase
    end

    // Output flags follow the read position, matching buffer read latency
    always_comb begin
        fl_d[0] = {rd_state_q == READ,
                   (rd_state_q == READ) && (rd_cnt_q == 3'd0),
                   (rd_state_q == READ) && (rd_cnt_q == 3'd7)};
        for (int i = 1; i < RD_LAT; i++) begin
            fl_d[i] = fl_q[i-1];
        end
        frame_cnt_d = frame_cnt_q + {7'd0, fl_q[RD_LAT-1][0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state_q  <= IDLE;
            idx_q       <= '0;
            gap_q       <= '0;
            in_ready_q  <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < PIPE_LAT; i++) dl_q[i] <= '0;
            for (int i = 0; i < S4_DLY; i++)   s4_q[i] <= '0;
            wr_bank_q   <= 1'b0;
            rd_state_q  <= RIDLE;
            rd_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            for (int i = 0; i < RD_LAT; i++)   fl_q[i] <= '0;
            frame_cnt_q <= '0;
        end else begin
            in_state_q  <= in_state_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            in_ready_q  <= in_ready_d;
            err_q       <= err_d;
            for (int i = 0; i < PIPE_LAT; i++) dl_q[i] <= dl_d[i];
            for (int i = 0; i < S4_DLY; i++)   s4_q[i] <= s4_d[i];
            wr_bank_q   <= wr_bank_d;
            rd_state_q  <= rd_state_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_bank_q   <= rd_bank_d;
            for (int i = 0; i < RD_LAT; i++)   fl_q[i] <= fl_d[i];
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign s8_ctl    = idx_q;
    assign s4_ctl    = s4_q[S4_DLY-1];
    assign wr_en     = w_tok_out[4];
    assign wr_addr   = w_tok_out[1] ? 2'd0 : w_tok_out[3:2];
    assign wr_bank   = wr_bank_q;
    assign rd_en     = (rd_state_q == READ);
    assign rd_bank   = rd_bank_q;
`ifdef FFT_BITREV_RD_EN
    assign rd_addr   = {rd_cnt_q[0], rd_cnt_q[1], rd_cnt_q[2]};
`else
    assign rd_addr   = rd_cnt_q;
`endif
    assign out_valid = fl_q[RD_LAT-1][2];
    assign out_first = fl_q[RD_LAT-1][1];
    assign out_last  = fl_q[RD_LAT-1][0];
    assign frame_cnt = frame_cnt_q;
    assign err_abort = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_frame_sched
// Purpose  : Self-checking bench for fft_frame_sched. An event-based model
//            schedules expected write/read/output activity per cycle from
//            each accepted pair, then every DUT output is compared.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_frame_sched;

    localparam int MAXC = 2300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] s8_ctl, s4_ctl, wr_addr;
    logic       wr_en, wr_bank, rd_en, rd_bank;
    logic [2:0] rd_addr;
    logic       out_valid, out_first, out_last, err_abort;
    logic [7:0] frame_cnt;

    always #5 clk = ~clk;

    fft_frame_sched dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s8_ctl    (s8_ctl),
        .s4_ctl    (s4_ctl),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_bank   (wr_bank),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_bank   (rd_bank),
        .out_valid (out_valid),
        .out_first (out_first),
        .out_last  (out_last),
        .frame_cnt (frame_cnt),
        .err_abort (err_abort)
    );

    int checks = 0;
    int errors = 0;
    int stim      [MAXC];
    int e_wr_en   [MAXC];
    int e_wr_addr [MAXC];
    int e_wr_bank [MAXC];
    int e_rd_en   [MAXC];
    int e_rd_addr [MAXC];
    int e_rd_bank [MAXC];
    int e_ov      [MAXC];
    int e_of      [MAXC];
    int e_ol      [MAXC];
    int e_fcinc   [MAXC];
    int e_s4      [MAXC];
    int npos, ready_from, frames, err_from, fc;
    int rd_order [8];

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"},  -1, in_ready, 0);
        chk({tag, "_s8"},        -1, s8_ctl, 0);
        chk({tag, "_s4"},        -1, s4_ctl, 0);
        chk({tag, "_wr"},        -1, {wr_en, wr_addr, wr_bank}, 0);
        chk({tag, "_rd"},        -1, {rd_en, rd_addr, rd_bank}, 0);
        chk({tag, "_out"},       -1, {out_valid, out_first, out_last}, 0);
        chk({tag, "_frame_cnt"}, -1, frame_cnt, 0);
        chk({tag, "_err"},       -1, err_abort, 0);
    endtask

    task automatic model_clear();
        for (int i = 0; i < MAXC; i++) begin
            stim[i] = 0; e_wr_en[i] = 0; e_wr_addr[i] = 0; e_wr_bank[i] = 0;
            e_rd_en[i] = 0; e_rd_addr[i] = 0; e_rd_bank[i] = 0;
            e_ov[i] = 0; e_of[i] = 0; e_ol[i] = 0; e_fcinc[i] = 0; e_s4[i] = -1;
        end
        npos = 0; ready_from = 0; frames = 0; err_from = 2 * MAXC; fc = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1 check_zero("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("in_ready_after_release", -1, in_ready, 0);
        @(posedge clk);
    endtask

    // Model: each accepted pair schedules its own future write; a completed
    // frame schedules its 8 reads, output flags and frame count bump.
    task automatic step(input int c);
        bit rdy;
        rdy = (c >= ready_from);
        chk("in_ready", c, in_ready, rdy);
        if (rdy && stim[c] != 0) begin
            chk("s8_ctl", c, s8_ctl, npos);
            e_s4[c+4]      = npos;
            e_wr_en[c+12]   = 1;
            e_wr_addr[c+12] = npos;
            e_wr_bank[c+12] = frames % 2;
            npos++;
            if (npos == 4) begin
                for (int k = 0; k < 8; k++) begin
                    e_rd_en[c+13+k]   = 1;
                    e_rd_addr[c+13+k] = rd_order[k];
                    e_rd_bank[c+13+k] = frames % 2;
                    e_ov[c+15+k]      = 1;
                end
                e_of[c+15]    = 1;
                e_ol[c+22]    = 1;
                e_fcinc[c+23] = 1;
                ready_from = c + 5;
                npos = 0;
                frames++;
            end
        end else if (npos > 0) begin
            if (err_from > c + 1) err_from = c + 1;
            npos = 0;
        end
        if (e_s4[c] >= 0) chk("s4_ctl", c, s4_ctl, e_s4[c]);
        chk("wr_en", c, wr_en, e_wr_en[c]);
        if (e_wr_en[c] != 0) begin
            chk("wr_addr", c, wr_addr, e_wr_addr[c]);
            chk("wr_bank", c, wr_bank, e_wr_bank[c]);
        end
        chk("rd_en", c, rd_en, e_rd_en[c]);
        if (e_rd_en[c] != 0) begin
            chk("rd_addr", c, rd_addr, e_rd_addr[c]);
            chk("rd_bank", c, rd_bank, e_rd_bank[c]);
        end
        chk("out_valid", c, out_valid, e_ov[c]);
        chk("out_first", c, out_first, e_of[c]);
        chk("out_last",  c, out_last,  e_ol[c]);
        fc = (fc + e_fcinc[c]) % 256;
        chk("frame_cnt", c, frame_cnt, fc);
        chk("err_abort", c, err_abort, (c >= err_from));
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            #1 in_valid = (stim[c] != 0);
            @(negedge clk);
            step(c);
            @(posedge clk);
        end
    endtask

    initial begin
`ifdef FFT_BITREV_RD_EN
        rd_order = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
        rd_order = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
        // Single frame
        model_clear();
        for (int i = 0; i < 4; i++) stim[i] = 1;
        do_reset();
        run_cycles(40);

        // Continuous input, long enough to wrap frame_cnt
        model_clear();
        for (int i = 0; i < 2100; i++) stim[i] = 1;
        do_reset();
        run_cycles(2140);

        // Abort mid-frame, then a clean frame
        model_clear();
        stim[0] = 1; stim[1] = 1;
        for (int i = 5; i < 9; i++) stim[i] = 1;
        do_reset();
        run_cycles(45);

        // Reset while reading
        model_clear();
        for (int i = 0; i < 4; i++) stim[i] = 1;
        do_reset();
        run_cycles(19);
        #1 in_valid = 1'b0;
        #1 rst = 1'b1;
        #1 check_zero("mid_read_rst");
        model_clear();
        for (int i = 0; i < 4; i++) stim[i] = 1;
        do_reset();
        run_cycles(40);

        // Randomized traffic with stalls and aborts
        for (int s = 0; s < 4; s++) begin
            model_clear();
            for (int i = 0; i < 200; i++) stim[i] = ($urandom_range(0, 9) < 7 + (s % 3)) ? 1 : 0;
            do_reset();
            run_cycles(230);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
